// File: rtl/cbus_arbiter.sv
// Two-master CBus arbiter: holds a grant for a whole transaction, 1-cycle arbitration, 1-cycle IDLE bubble between grants.
// Backpressure: o_ready/o_last pass straight through to the granted master; the other master sees ready=0 until its turn.
module cbus_arbiter #(
  parameter int RR     = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                m0_valid,
  input  logic                m0_is_write,
  input  logic [2:0]          m0_size,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W/8-1:0] m0_strobe,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [3:0]          m0_len,
  output logic                m0_ready,
  output logic                m0_last,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_valid,
  input  logic                m1_is_write,
  input  logic [2:0]          m1_size,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W/8-1:0] m1_strobe,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [3:0]          m1_len,
  output logic                m1_ready,
  output logic                m1_last,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                o_valid,
  output logic                o_is_write,
  output logic [2:0]          o_size,
  output logic [ADDR_W-1:0]   o_addr,
  output logic [DATA_W/8-1:0] o_strobe,
  output logic [DATA_W-1:0]   o_wdata,
  output logic [3:0]          o_len,
  input  logic                o_ready,
  input  logic                o_last,
  input  logic [DATA_W-1:0]   o_rdata
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state;
  logic   grant;
  logic   last_grant;
  logic   next_grant;

  // On a tie, round-robin picks whoever did not win last; fixed priority always favours data.
  always_comb begin
    next_grant = m1_valid;
    if (m0_valid && m1_valid) begin
      next_grant = (RR != 0) ? ~last_grant : 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (m0_valid || m1_valid) begin
            state <= BUSY;
            grant <= next_grant;
          end
        end
        BUSY: begin
          if (o_valid && o_ready && o_last) begin
            state      <= IDLE;
            last_grant <= grant;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_valid    = 1'b0;
    o_is_write = 1'b0;
    o_size     = '0;
    o_addr     = '0;
    o_strobe   = '0;
    o_wdata    = '0;
    o_len      = '0;
    m0_ready   = 1'b0;
    m0_last    = 1'b0;
    m0_rdata   = '0;
    m1_ready   = 1'b0;
    m1_last    = 1'b0;
    m1_rdata   = '0;
    if (state == BUSY) begin
      if (grant) begin
        o_valid    = m1_valid;
        o_is_write = m1_is_write;
        o_size     = m1_size;
        o_addr     = m1_addr;
        o_strobe   = m1_strobe;
        o_wdata    = m1_wdata;
        o_len      = m1_len;
        m1_ready   = o_ready;
        m1_last    = o_last;
        m1_rdata   = o_rdata;
      end else begin
        o_valid    = m0_valid;
        o_is_write = m0_is_write;
        o_size     = m0_size;
        o_addr     = m0_addr;
        o_strobe   = m0_strobe;
        o_wdata    = m0_wdata;
        o_len      = m0_len;
        m0_ready   = o_ready;
        m0_last    = o_last;
        m0_rdata   = o_rdata;
      end
    end
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter: round-robin instance checked by a vector table and burst/reset
// sequences, fixed-priority instance checked for master-1 preference.
module tb_cbus_arbiter;

  localparam logic [31:0] A0 = 32'hBFC0_0000;
  localparam logic [31:0] A1 = 32'h8000_1000;

  logic        clk, resetn;
  logic        m0_valid, m0_is_write, m1_valid, m1_is_write;
  logic [2:0]  m0_size, m1_size;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_strobe, m1_strobe, m0_len, m1_len;
  logic        o_ready, o_last;
  logic [31:0] o_rdata;

  logic        m0_ready, m0_last, m1_ready, m1_last;
  logic [31:0] m0_rdata, m1_rdata;
  logic        o_valid, o_is_write;
  logic [2:0]  o_size;
  logic [31:0] o_addr, o_wdata;
  logic [3:0]  o_strobe, o_len;

  logic        fp_m0_ready, fp_m0_last, fp_m1_ready, fp_m1_last;
  logic [31:0] fp_m0_rdata, fp_m1_rdata;
  logic        fp_o_valid, fp_o_is_write;
  logic [2:0]  fp_o_size;
  logic [31:0] fp_o_addr, fp_o_wdata;
  logic [3:0]  fp_o_strobe, fp_o_len;

  int tests = 0;
  int fails = 0;

  cbus_arbiter #(.RR(1), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_is_write(m0_is_write), .m0_size(m0_size), .m0_addr(m0_addr),
    .m0_strobe(m0_strobe), .m0_wdata(m0_wdata), .m0_len(m0_len),
    .m0_ready(m0_ready), .m0_last(m0_last), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_is_write(m1_is_write), .m1_size(m1_size), .m1_addr(m1_addr),
    .m1_strobe(m1_strobe), .m1_wdata(m1_wdata), .m1_len(m1_len),
    .m1_ready(m1_ready), .m1_last(m1_last), .m1_rdata(m1_rdata),
    .o_valid(o_valid), .o_is_write(o_is_write), .o_size(o_size), .o_addr(o_addr),
    .o_strobe(o_strobe), .o_wdata(o_wdata), .o_len(o_len),
    .o_ready(o_ready), .o_last(o_last), .o_rdata(o_rdata)
  );

  cbus_arbiter #(.RR(0), .ADDR_W(32), .DATA_W(32)) dut_fp (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_is_write(m0_is_write), .m0_size(m0_size), .m0_addr(m0_addr),
    .m0_strobe(m0_strobe), .m0_wdata(m0_wdata), .m0_len(m0_len),
    .m0_ready(fp_m0_ready), .m0_last(fp_m0_last), .m0_rdata(fp_m0_rdata),
    .m1_valid(m1_valid), .m1_is_write(m1_is_write), .m1_size(m1_size), .m1_addr(m1_addr),
    .m1_strobe(m1_strobe), .m1_wdata(m1_wdata), .m1_len(m1_len),
    .m1_ready(fp_m1_ready), .m1_last(fp_m1_last), .m1_rdata(fp_m1_rdata),
    .o_valid(fp_o_valid), .o_is_write(fp_o_is_write), .o_size(fp_o_size), .o_addr(fp_o_addr),
    .o_strobe(fp_o_strobe), .o_wdata(fp_o_wdata), .o_len(fp_o_len),
    .o_ready(o_ready), .o_last(o_last), .o_rdata(o_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v0, v1, rdy, lst;
    logic [31:0] rdata;
    logic        ev;
    logic [31:0] eaddr;
    logic        er0, er1, el0, el1;
    logic [31:0] ed0, ed1;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs change just after the falling edge; the rising edge commits state.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    m0_valid = 1'b0; m0_is_write = 1'b0; m0_size = 3'd2; m0_addr = A0;
    m0_strobe = 4'h0; m0_wdata = '0; m0_len = 4'd0;
    m1_valid = 1'b0; m1_is_write = 1'b0; m1_size = 3'd2; m1_addr = A1;
    m1_strobe = 4'h0; m1_wdata = '0; m1_len = 4'd0;
    o_ready = 1'b0; o_last = 1'b0; o_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    int hs;
    logic [4:0] rdy_pat;

    //            v0    v1    rdy   lst   rdata          ev    eaddr  er0   er1   el0   el1   ed0            ed1
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h3C1DBFC0, 1'b1, A0,    1'b1, 1'b0, 1'b1, 1'b0, 32'h3C1DBFC0, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, A1,    1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h12345678, 1'b1, A1,    1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        32'h12345678};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h55AA55AA, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0,        1'b1, A0,    1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h11110000, 1'b1, A0,    1'b1, 1'b0, 1'b0, 1'b0, 32'h11110000, 32'h0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h22220000, 1'b1, A0,    1'b1, 1'b0, 1'b1, 1'b0, 32'h22220000, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h33330000, 1'b1, A1,    1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        32'h33330000};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h44440000, 1'b1, A0,    1'b1, 1'b0, 1'b1, 1'b0, 32'h44440000, 32'h0};

    // Reset state, with both masters requesting and converter handshaking.
    idle_inputs();
    resetn = 1'b0;
    m0_valid = 1'b1; m1_valid = 1'b1; o_ready = 1'b1; o_last = 1'b1; o_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    #2;
    check("reset o_valid", o_valid, 0);
    check("reset o_addr", o_addr, 0);
    check("reset m0_ready", m0_ready, 0);
    check("reset m1_rdata", m1_rdata, 0);
    do_reset();

    for (int i = 0; i < 14; i++) begin
      m0_valid = vecs[i].v0; m1_valid = vecs[i].v1;
      o_ready = vecs[i].rdy; o_last = vecs[i].lst; o_rdata = vecs[i].rdata;
      #2;
      check($sformatf("vec%0d o_valid", i), o_valid, vecs[i].ev);
      check($sformatf("vec%0d o_addr", i), o_addr, vecs[i].eaddr);
      check($sformatf("vec%0d m0_ready", i), m0_ready, vecs[i].er0);
      check($sformatf("vec%0d m1_ready", i), m1_ready, vecs[i].er1);
      check($sformatf("vec%0d m0_last", i), m0_last, vecs[i].el0);
      check($sformatf("vec%0d m1_last", i), m1_last, vecs[i].el1);
      check($sformatf("vec%0d m0_rdata", i), m0_rdata, vecs[i].ed0);
      check($sformatf("vec%0d m1_rdata", i), m1_rdata, vecs[i].ed1);
      step();
    end

    // Fixed priority: m1 wins four arbitrations in a row with m0 always requesting.
    do_reset();
    for (int t = 0; t < 4; t++) begin
      m0_valid = 1'b1; m1_valid = 1'b1; o_ready = 1'b0; o_last = 1'b0; o_rdata = '0;
      #2;
      check($sformatf("fp%0d idle o_valid", t), fp_o_valid, 0);
      step();
      o_ready = 1'b1; o_last = 1'b1; o_rdata = 32'hA000_0000 + t;
      #2;
      check($sformatf("fp%0d o_addr", t), fp_o_addr, A1);
      check($sformatf("fp%0d m1_ready", t), fp_m1_ready, 1);
      check($sformatf("fp%0d m1_rdata", t), fp_m1_rdata, 32'hA000_0000 + t);
      check($sformatf("fp%0d m0_ready", t), fp_m0_ready, 0);
      step();
    end

    // Burst write on m1, len=3, ready pattern 1,0,1,1,1 with last on the 4th handshake.
    do_reset();
    m1_valid = 1'b1; m1_is_write = 1'b1; m1_len = 4'd3; m1_strobe = 4'hF;
    m1_wdata = 32'hCAFE_0001; m1_size = 3'd2;
    step();
    rdy_pat = 5'b11101;
    hs = 0;
    for (int b = 0; b < 5; b++) begin
      o_ready = rdy_pat[b];
      o_last = rdy_pat[b] && (hs == 3);
      #2;
      check($sformatf("burst%0d o_valid", b), o_valid, 1);
      check($sformatf("burst%0d m1_ready", b), m1_ready, {63'd0, rdy_pat[b]});
      check($sformatf("burst%0d m0_ready", b), m0_ready, 0);
      check($sformatf("burst%0d o_len", b), o_len, 3);
      check($sformatf("burst%0d o_is_write", b), o_is_write, 1);
      check($sformatf("burst%0d o_wdata", b), o_wdata, m1_wdata);
      check($sformatf("burst%0d o_strobe", b), o_strobe, 4'hF);
      step();
      if (rdy_pat[b]) hs++;
      m1_wdata = m1_wdata + 1;
    end
    o_ready = 1'b0; o_last = 1'b0;
    #2;
    check("burst bubble o_valid", o_valid, 0);
    step();
    #2;
    check("burst regrant o_valid", o_valid, 1);

    // Asynchronous reset on beat 2 of a 4-beat m1 burst.
    do_reset();
    m1_valid = 1'b1; m1_is_write = 1'b1; m1_len = 4'd3; m1_strobe = 4'hF;
    step();
    o_ready = 1'b1;
    step();
    m0_valid = 1'b1;
    #2;
    check("arst pre o_valid", o_valid, 1);
    check("arst pre m1_ready", m1_ready, 1);
    resetn = 1'b0;
    #1;
    check("arst o_valid", o_valid, 0);
    check("arst m1_ready", m1_ready, 0);
    check("arst o_addr", o_addr, 0);
    @(negedge clk);
    resetn = 1'b1;
    o_ready = 1'b0;
    #2;
    check("arst idle o_valid", o_valid, 0);
    step();
    o_ready = 1'b1; o_last = 1'b1; o_rdata = 32'h0BAD_F00D;
    #2;
    check("arst regrant o_addr", o_addr, A0);
    check("arst regrant m0_ready", m0_ready, 1);
    check("arst regrant m0_rdata", m0_rdata, 32'h0BAD_F00D);
    check("arst regrant m1_ready", m1_ready, 0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
